decoder_arbiter: RTL and testbench

DECODER_ARBITER -- requirements
Module: decoder_arbiter

---
 rtl/decoder_arbiter.sv | 142 ++++++++++++++
 tb/tb_decoder_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/decoder_arbiter.sv
// rtl/decoder_arbiter.sv - 8-way round-robin arbiter with registered active-low one-hot select
// Optional hold timeout compiled in by defining DECODER_ARB_TIMEOUT_EN.

module decoder_arbiter #(
  parameter int HOLD_MAX = 15
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iEna,
  input  logic [7:0] iReq,
  output logic [7:0] oSel,
  output logic [2:0] oIdx,
  output logic       oValid,
  output logic       oTimeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;

  logic [2:0] winner;
  logic       found;
  logic [2:0] cand;
  logic       release_grant;
  logic       hold_expired;

  // Search starts one past the last winner; offset 8 wraps back onto ptr itself.
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    cand   = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!found && iReq[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef DECODER_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  assign hold_expired = (hold_q == 8'(HOLD_MAX - 1));

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      hold_q <= 8'd0;
    end else begin
      hold_q <= hold_d;
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (state_q != ST_GRANT) begin
      hold_d = 8'd0;
    end else if (!release_grant) begin
      hold_d = hold_q + 8'd1;
    end
  end
`else
  logic [7:0] unused_hold_max;

  assign unused_hold_max = 8'(HOLD_MAX);
  assign hold_expired    = 1'b0;
`endif

  assign release_grant = !iEna || !iReq[idx_q] || hold_expired;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        sel_d   = 8'hFF;
        valid_d = 1'b0;
        if (iEna && found) begin
          state_d = ST_GRANT;
          idx_d   = winner;
          sel_d   = ~(8'b1 << winner);
          valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_grant) begin
          state_d   = ST_GAP;
          ptr_d     = idx_q;
          sel_d     = 8'hFF;
          valid_d   = 1'b0;
          // Only a forced release of a still-requesting owner counts as a timeout.
          timeout_d = hold_expired && iEna && iReq[idx_q];
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 8'hFF;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 3'd7;
      idx_q     <= 3'd0;
      sel_q     <= 8'hFF;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign oSel     = sel_q;
  assign oIdx     = idx_q;
  assign oValid   = valid_q;
  assign oTimeout = timeout_q;

endmodule

// File: tb/tb_decoder_arbiter.sv
// tb/tb_decoder_arbiter.sv - directed self-checking bench for decoder_arbiter

module tb_decoder_arbiter;

  logic       iClk;
  logic       iRst_n;
  logic       iEna;
  logic [7:0] iReq;
  logic [7:0] oSel;
  logic [2:0] oIdx;
  logic       oValid;
  logic       oTimeout;

  int n_total;
  int n_pass;

  decoder_arbiter #(
    .HOLD_MAX(4)
  ) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iEna    (iEna),
    .iReq    (iReq),
    .oSel    (oSel),
    .oIdx    (oIdx),
    .oValid  (oValid),
    .oTimeout(oTimeout)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [2:0] idx);
    check({tag, "_valid"}, {15'd0, oValid}, 16'd1);
    check({tag, "_idx"}, {13'd0, oIdx}, {13'd0, idx});
    check({tag, "_sel"}, {8'd0, oSel}, {8'd0, ~(8'b1 << idx)});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {15'd0, oValid}, 16'd0);
    check({tag, "_sel"}, {8'd0, oSel}, 16'h00FF);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    iRst_n  = 1'b0;
    iEna    = 1'b1;
    iReq    = 8'h81;

    // Reset state, then first grant one edge after release.
    step();
    step();
    check_idle("rst");
    check("rst_idx", {13'd0, oIdx}, 16'd0);
    check("rst_tmo", {15'd0, oTimeout}, 16'd0);
    iRst_n = 1'b1;
    step();
    check_grant("first", 3'd0);

    iReq = 8'h80;
    step();
    check_idle("gap0");
    check("gap0_idx", {13'd0, oIdx}, 16'd0);
    step();
    check_grant("second", 3'd7);

    // Round-robin sweep with every requester active.
    iReq = 8'h7F;
    step();
    check_idle("gap7");
    iReq = 8'hFF;
    step();
    check_grant("rr0", 3'd0);
    for (int k = 1; k <= 8; k++) begin
      iReq = 8'hFF & ~(8'b1 << 3'((k - 1) % 8));
      step();
      check_idle($sformatf("rr_gap%0d", k));
      iReq = 8'hFF;
      step();
      check_grant($sformatf("rr%0d", k), 3'(k % 8));
    end

    iReq = 8'h00;
    step();
    check_idle("rel_gap");
    step();
    check_idle("rel_idle");

    iReq = 8'h0C;
    step();
    check_grant("hold2", 3'd2);
`ifdef DECODER_ARB_TIMEOUT_EN
    for (int c = 2; c <= 4; c++) begin
      step();
      check_grant($sformatf("hold2_c%0d", c), 3'd2);
      check($sformatf("hold2_tmo%0d", c), {15'd0, oTimeout}, 16'd0);
    end
    step();
    check_idle("tmo_gap");
    check("tmo_pulse", {15'd0, oTimeout}, 16'd1);
    step();
    check_grant("after_tmo", 3'd3);
    check("tmo_clear", {15'd0, oTimeout}, 16'd0);
`else
    for (int c = 0; c < 100; c++) begin
      step();
      check($sformatf("hold_c%0d", c), {12'd0, oValid, oIdx, 1'b0, oTimeout}, {12'd0, 1'b1, 3'd2, 1'b0, 1'b0});
    end
`endif
    iReq = 8'h00;
    step();
    check_idle("hold_gap");
    step();
    check_idle("hold_idle");

    // Enable dropped mid-grant.
    iReq = 8'h20;
    step();
    check_grant("ena5", 3'd5);
    iEna = 1'b0;
    step();
    check_idle("ena_off_gap");
    for (int c = 0; c < 3; c++) begin
      step();
      check_idle($sformatf("ena_off%0d", c));
    end
    iEna = 1'b1;
    step();
    check_grant("ena_on", 3'd5);

    // Asynchronous reset between edges.
    #3;
    iRst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_idx", {13'd0, oIdx}, 16'd0);
    iReq = 8'h10;
    step();
    iRst_n = 1'b1;
    step();
    check_grant("post_rst", 3'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
